// File: rtl/tcnt_apb_pkg.sv
// Shared APB types, LFSR constants and the LFSR step function.
package tcnt_apb_pkg;

    typedef enum logic {READ = 1'b0, WRITE = 1'b1} xact_type_e;
    typedef enum logic {ZERO = 1'b0, RANDOM = 1'b1} read_default_value_e;
    typedef enum logic {NORMAL = 1'b0, PRIVILEGED = 1'b1} pprot0_enum;
    typedef enum logic {SECURE = 1'b0, NON_SECURE = 1'b1} pprot1_enum;
    typedef enum logic {DATA = 1'b0, INSTRUCTION = 1'b1} pprot2_enum;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} apb_slv_state_e;

    localparam logic [31:0] LFSR_SEED = 32'hACE1_2468;
    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois mask
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/tcnt_apb_lfsr.sv
// 32-bit Galois LFSR; steps once per cycle while adv is high.
module tcnt_apb_lfsr
    import tcnt_apb_pkg::*;
(
    input  logic        pclk,
    input  logic        presetn,
    input  logic        adv,
    output logic [31:0] value
);

    logic [31:0] lfsr_q, lfsr_d;

    // next state: step only when asked
    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) lfsr_d = lfsr_next(lfsr_q);
    end

    // state register, reset to the seed
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) lfsr_q <= LFSR_SEED;
        else          lfsr_q <= lfsr_d;
    end

    assign value = lfsr_q;

endmodule

// File: rtl/tcnt_apb_slave_mem.sv
// APB completer backed by a word memory, with wait states, byte strobes,
// a secure upper half and a ZERO/RANDOM default for unwritten words.
module tcnt_apb_slave_mem
    import tcnt_apb_pkg::*;
#(
    parameter int                  ADDR_WIDTH   = 16,
    parameter int                  DATA_WIDTH   = 32,
    parameter int                  DEPTH        = 64,
    parameter read_default_value_e READ_DEFAULT = ZERO
)(
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [2:0]              pprot,
    input  logic [3:0]              cfg_wait,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic                    proto_err
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int SHIFT = $clog2(NB);
    localparam int MAW   = $clog2(DEPTH);

    apb_slv_state_e        state_q, state_d;
    logic [3:0]            wcnt_q, wcnt_d;
    logic [MAW-1:0]        midx_q, midx_d;
    logic                  pwrite_q, pwrite_d;
    logic                  err_q, err_d;
    logic                  proto_err_q, proto_err_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         pstrb_q, pstrb_d;
    logic [DEPTH-1:0]      wr_flag_q, wr_flag_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [32:0]           idx;
    logic                  complete, mem_we, lfsr_adv;
    logic [DATA_WIDTH-1:0] merged, rd_word;
    logic [31:0]           lfsr_val;

    // FSM next state; request fields are captured on the setup cycle only
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        midx_d      = midx_q;
        pwrite_d    = pwrite_q;
        err_d       = err_q;
        wdata_d     = wdata_q;
        pstrb_d     = pstrb_q;
        proto_err_d = 1'b0;
        idx         = 33'(paddr) >> SHIFT;
        case (state_q)
            IDLE: begin
                if (penable) begin
                    proto_err_d = 1'b1;
                end else if (psel) begin
                    state_d  = ACCESS;
                    wcnt_d   = cfg_wait;
                    midx_d   = idx[MAW-1:0];
                    pwrite_d = pwrite;
                    wdata_d  = pwdata;
                    pstrb_d  = pstrb;
                    // out of range, or non-secure access to the upper half
                    err_d    = (idx >= 33'(DEPTH)) ||
                               ((idx >= 33'(DEPTH / 2)) && (pprot[1] == NON_SECURE));
                end
            end
            ACCESS: begin
                if (psel && penable) begin
                    if (wcnt_q != 4'd0) wcnt_d  = wcnt_q - 4'd1;
                    else                state_d = IDLE;
                end else begin
                    // master left the access phase early: abort without commit
                    state_d     = IDLE;
                    wcnt_d      = 4'd0;
                    proto_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and request registers
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            wcnt_q      <= 4'd0;
            midx_q      <= '0;
            pwrite_q    <= 1'b0;
            err_q       <= 1'b0;
            wdata_q     <= '0;
            pstrb_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            midx_q      <= midx_d;
            pwrite_q    <= pwrite_d;
            err_q       <= err_d;
            wdata_q     <= wdata_d;
            pstrb_q     <= pstrb_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign complete = (state_q == ACCESS) && psel && penable && (wcnt_q == 4'd0);
    assign mem_we   = complete && pwrite_q && !err_q;
    assign lfsr_adv = complete && !pwrite_q && !err_q && !wr_flag_q[midx_q] &&
                      (READ_DEFAULT == RANDOM);

    // byte-lane merge of latched write data over the stored word
    always_comb begin
        merged = mem_q[midx_q];
        for (int i = 0; i < NB; i++) begin
            if (pstrb_q[i]) merged[i*8 +: 8] = wdata_q[i*8 +: 8];
        end
    end

    // written flags: an all-zero strobe does not count as a write
    always_comb begin
        wr_flag_d = wr_flag_q;
        if (mem_we && (pstrb_q != '0)) wr_flag_d[midx_q] = 1'b1;
    end

    // written flags reset; memory contents do not
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) wr_flag_q <= '0;
        else          wr_flag_q <= wr_flag_d;
    end

    // memory array, committed at the end of the pready cycle
    always_ff @(posedge pclk) begin
        if (mem_we) mem_q[midx_q] <= merged;
    end

    tcnt_apb_lfsr u_lfsr (
        .pclk    (pclk),
        .presetn (presetn),
        .adv     (lfsr_adv),
        .value   (lfsr_val)
    );

    // read data from stored word or the default source
    always_comb begin
        rd_word = '0;
        if (wr_flag_q[midx_q])           rd_word = mem_q[midx_q];
        else if (READ_DEFAULT == RANDOM) rd_word = lfsr_val[DATA_WIDTH-1:0];
    end

    // outputs depend only on registered state
    assign pready    = (state_q == ACCESS) && (wcnt_q == 4'd0);
    assign pslverr   = pready && err_q;
    assign prdata    = (pready && !err_q && !pwrite_q) ? rd_word : '0;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_tcnt_apb_slave_mem.sv
// Directed bench: a ZERO-default and a RANDOM-default instance share stimulus.
module tb_tcnt_apb_slave_mem;
    import tcnt_apb_pkg::*;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [15:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [2:0]  pprot = '0;
    logic [3:0]  cfg_wait = '0;

    logic [31:0] prdata_z, prdata_r;
    logic        pready_z, pready_r, pslverr_z, pslverr_r, proto_err_z, proto_err_r;

    int n_chk = 0;
    int n_err = 0;

    always #5 pclk = ~pclk;

    tcnt_apb_slave_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(64), .READ_DEFAULT(ZERO)) u_dut_z (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .cfg_wait(cfg_wait),
        .prdata(prdata_z), .pready(pready_z), .pslverr(pslverr_z), .proto_err(proto_err_z)
    );

    tcnt_apb_slave_mem #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(64), .READ_DEFAULT(RANDOM)) u_dut_r (
        .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .cfg_wait(cfg_wait),
        .prdata(prdata_r), .pready(pready_r), .pslverr(pslverr_r), .proto_err(proto_err_r)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // one full transfer; entered and left at #1 after a rising edge
    task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [3:0] sb, input logic [2:0] pr,
                        output logic [31:0] rz, output logic [31:0] rr,
                        output logic err, output int lat);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = wd; pstrb = sb; pprot = pr;
        @(posedge pclk); #1;
        penable = 1'b1;
        lat = 1;
        while (!pready_z && lat < 40) begin
            @(posedge pclk); #1;
            lat++;
        end
        lat++;
        rz  = prdata_z;
        rr  = prdata_r;
        err = pslverr_z | pslverr_r;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rz, rr;
    logic        er;
    int          lat;

    initial begin
        // reset state
        @(posedge pclk); #1;
        chk("reset_outs", {27'd0, pready_z, pslverr_z, proto_err_z, |prdata_z, |prdata_r}, 32'd0);
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;

        // zero-wait write then read
        cfg_wait = 4'd0;
        xfer(1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 3'b000, rz, rr, er, lat);
        chk("w0_lat", 32'(lat), 32'd2);
        chk("w0_err", {31'd0, er}, 32'd0);
        xfer(1'b0, 16'h0004, 32'h0, 4'h0, 3'b000, rz, rr, er, lat);
        chk("r0_lat", 32'(lat), 32'd2);
        chk("r0_data_z", rz, 32'hDEADBEEF);
        chk("r0_data_r", rr, 32'hDEADBEEF);
        chk("r0_err", {31'd0, er}, 32'd0);

        // wait states and partial strobe
        cfg_wait = 4'd3;
        xfer(1'b1, 16'h0008, 32'hAABBCCDD, 4'hF, 3'b000, rz, rr, er, lat);
        chk("w3_lat", 32'(lat), 32'd5);
        xfer(1'b1, 16'h0008, 32'h11223344, 4'b0101, 3'b000, rz, rr, er, lat);
        chk("w3s_lat", 32'(lat), 32'd5);
        xfer(1'b0, 16'h0008, 32'h0, 4'h0, 3'b000, rz, rr, er, lat);
        chk("strb_data", rz, 32'hAA22CC44);

        // never-written reads; errored read must not step the LFSR
        cfg_wait = 4'd0;
        xfer(1'b0, 16'h0010, 32'h0, 4'h0, 3'b000, rz, rr, er, lat);
        chk("nw_zero", rz, 32'h0);
        chk("nw_rand1", rr, 32'hACE12468);
        xfer(1'b0, 16'h0100, 32'h0, 4'h0, 3'b000, rz, rr, er, lat);
        chk("oor_err", {31'd0, er}, 32'd1);
        chk("oor_data", rz | rr, 32'h0);
        xfer(1'b0, 16'h0014, 32'h0, 4'h0, 3'b000, rz, rr, er, lat);
        chk("nw_rand2", rr, 32'h56709234);

        // secure region
        xfer(1'b1, 16'h0080, 32'h12345678, 4'hF, 3'b010, rz, rr, er, lat);
        chk("sec_ns_werr", {31'd0, er}, 32'd1);
        xfer(1'b0, 16'h0080, 32'h0, 4'h0, 3'b000, rz, rr, er, lat);
        chk("sec_unchanged", rz, 32'h0);
        chk("nw_rand3", rr, 32'h2B38491A);
        xfer(1'b1, 16'h0080, 32'h12345678, 4'hF, 3'b000, rz, rr, er, lat);
        chk("sec_s_werr", {31'd0, er}, 32'd0);
        xfer(1'b0, 16'h0080, 32'h0, 4'h0, 3'b000, rz, rr, er, lat);
        chk("sec_s_rd", rz, 32'h12345678);
        xfer(1'b0, 16'h0080, 32'h0, 4'h0, 3'b010, rz, rr, er, lat);
        chk("sec_ns_rerr", {31'd0, er}, 32'd1);
        chk("sec_ns_rdata", rz, 32'h0);

        // psel dropped mid-wait
        cfg_wait = 4'd5;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h000C;
        pwdata = 32'hCAFEF00D; pstrb = 4'hF; pprot = 3'b000;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        chk("abort_perr", {30'd0, proto_err_z, proto_err_r}, 32'd3);
        chk("abort_rdy", {31'd0, pready_z}, 32'd0);
        @(posedge pclk); #1;
        chk("abort_pulse", {31'd0, proto_err_z}, 32'd0);
        cfg_wait = 4'd0;
        xfer(1'b0, 16'h000C, 32'h0, 4'h0, 3'b000, rz, rr, er, lat);
        chk("abort_nowr", rz, 32'h0);
        chk("nw_rand4", rr, 32'h159C248D);
        xfer(1'b0, 16'h000C, 32'h0, 4'h0, 3'b000, rz, rr, er, lat);
        chk("nw_rand5", rr, 32'h8AEE1245);

        // penable without setup
        penable = 1'b1;
        @(posedge pclk); #1;
        penable = 1'b0;
        chk("nosetup_perr", {31'd0, proto_err_z}, 32'd1);
        chk("nosetup_rdy", {31'd0, pready_z}, 32'd0);
        @(posedge pclk); #1;

        // reset in wait cycle 2 of a write
        cfg_wait = 4'd3;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0020;
        pwdata = 32'h55AA55AA; pstrb = 4'hF; pprot = 3'b000;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        presetn = 1'b0;
        #1;
        chk("rst_outs", {28'd0, pready_z, pslverr_z, proto_err_z, |prdata_z}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        cfg_wait = 4'd0;
        xfer(1'b0, 16'h0020, 32'h0, 4'h0, 3'b000, rz, rr, er, lat);
        chk("rst_drop_z", rz, 32'h0);
        chk("rst_seed_r", rr, 32'hACE12468);
        xfer(1'b0, 16'h0004, 32'h0, 4'h0, 3'b000, rz, rr, er, lat);
        chk("rst_flags", rz, 32'h0);
        chk("rst_rand2", rr, 32'h56709234);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tcnt_apb_slave_mem.md
# tcnt_apb_slave_mem

Synthesizable APB completer (responder) with a word-addressed backing memory, programmable wait states, PSTRB byte-lane writes, PPROT-based secure-region checking and a ZERO/RANDOM default for never-written locations. It is the responder-side counterpart to the APB master agent. It serves as a self-contained DUT-side stand-in in VIP-level benches, so that master sequences, monitors and scoreboards can be exercised against known-good RTL.

## Interface
Parameters:
- ADDR_WIDTH, 16: PADDR width; legal range 1..32 (paddr_width_enum).
- DATA_WIDTH, 32: PRDATA/PWDATA width; 8, 16 or 32 only (pdata_width_enum).
- DEPTH, 64: number of DATA_WIDTH words; power of two, at least 2.
- READ_DEFAULT, ZERO: read_default_value_e value returned for never-written words (ZERO or RANDOM).

Ports:
- pclk, in, 1: the single clock; all logic is rising-edge.
- presetn, in, 1: reset, asynchronous assert, active-low.
- psel, in, 1: select.
- penable, in, 1: access phase.
- pwrite, in, 1: 1 = WRITE, 0 = READ (xact_type_e).
- paddr, in, ADDR_WIDTH: byte address.
- pwdata, in, DATA_WIDTH: write data.
- pstrb, in, DATA_WIDTH/8: write byte strobes.
- pprot, in, 3: bit0 pprot0_enum, bit1 pprot1_enum, bit2 pprot2_enum.
- cfg_wait, in, 4: wait states inserted per transfer; sampled in the setup cycle.
- prdata, out, DATA_WIDTH: read data.
- pready, out, 1: transfer complete.
- pslverr, out, 1: transfer error.
- proto_err, out, 1: one-cycle pulse flagging a master protocol violation.

## Operation
- Word index: paddr >> log2(DATA_WIDTH/8). The low address bits are ignored.
- State machine:
  - States are IDLE and ACCESS; reset state is IDLE.
  - IDLE → ACCESS when psel=1 and penable=0. On this transition the block latches addr, pwrite, pwdata, pstrb and pprot, and loads wcnt from cfg_wait.
  - ACCESS with psel=1 and penable=1: while wcnt≠0, wcnt decrements each cycle. When wcnt=0, pready=1 for that cycle and the state returns to IDLE.
  - ACCESS with psel=0: abort. Return to IDLE, pulse proto_err, no memory update.
  - IDLE with penable=1: ignored, pulse proto_err, pready stays 0.
  - A change in paddr, pwrite, pwdata, pstrb or pprot during ACCESS is ignored; latched values are used.
- Error conditions, evaluated on the latched values:
  - Word index ≥ DEPTH (out of range).
  - Word index ≥ DEPTH/2 with pprot[1]=NON_SECURE (the upper half of memory is the secure region).
  - On error, pslverr=1 in the completion cycle, writes are suppressed, prdata=0, and the LFSR does not advance.
- Write completion:
  - Each byte lane i with pstrb[i]=1 is updated; other lanes are kept.
  - The word's written flag is set only if pstrb≠0.
- Read completion:
  - A written word returns its stored value.
  - A never-written word returns 0 if READ_DEFAULT=ZERO. If READ_DEFAULT=RANDOM, it returns the low DATA_WIDTH bits of the LFSR, which then advances exactly once.

## Timing
- Reset values: pready=0, pslverr=0, prdata=0, proto_err=0, state=IDLE, wcnt=0, all written flags cleared, LFSR=LFSR_SEED. Memory contents are not reset.
- pready, pslverr and prdata are decoded from registered state and wcnt, with no input-to-output combinational path. prdata and pslverr are 0 whenever pready=0.
- Latency with cfg_wait=N: setup cycle, then N access cycles with pready=0, then 1 access cycle with pready=1. A transfer occupies N+2 cycles.
- Back-to-back transfers: a new setup is accepted in the cycle immediately after completion.
- The write commits at the clock edge that ends the pready=1 cycle. A read in the next transfer sees the new data.
- presetn assertion mid-transfer: outputs go to reset values immediately; any in-flight write is dropped.

## Structure
- The following belong in the shared APB package, alongside the existing xact_type_e, read_default_value_e and pprot enums:
  - apb_slv_state_e (IDLE, ACCESS).
  - LFSR_SEED = 32'hACE1_2468.
  - LFSR polynomial taps: x^32+x^22+x^2+x+1, Galois form.
- One sub-module, tcnt_apb_lfsr: 32-bit Galois LFSR with advance-enable and asynchronous reset to LFSR_SEED.

## Test plan
- Zero-wait write then read: cfg_wait=0, WRITE paddr=0x04, pwdata=0xDEADBEEF, pstrb=4'hF, then READ 0x04 → pready in the 2nd cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
- Wait states and partial strobe: cfg_wait=3, write 0xAABBCCDD, then write 0x11223344 with pstrb=4'b0101 to the same address → 4 pready=0 cycles per transfer; read returns 0xAA22CC44.
- Never-written read:
  - With READ_DEFAULT=ZERO: → 0x0.
  - With READ_DEFAULT=RANDOM: two reads → first returns 0xACE12468, second returns the next LFSR value; an intervening pslverr read does not advance the LFSR.
- Error response: paddr=DEPTH*4 (out of range) → pslverr=1, prdata=0. A write to index DEPTH/2 with pprot=3'b010 → pslverr=1 and the memory is unchanged; the same write with pprot=3'b000 succeeds.
- Protocol violations: psel dropped mid-wait with cfg_wait=5 → proto_err pulse and no write. penable=1 without setup → proto_err pulse, pready stays 0.
- Reset mid-transfer: presetn low during wait cycle 2 of a write → outputs are 0 at once; after release, a read of that address returns the default value.
